c1weights_loader: RTL and testbench

Sequential reader for the conv1 weight ROM. On a start pulse it walks the ROM address space 0..KERNEL_SIZE-1, compensates for the ROM's one-cycle registered read latency, and assembles all weights into a flat parallel kernel bus for the conv1 MAC array. It sits between the weight ROM and the convolution datapath and signals completion with a one-cycle `done` pulse plus a level `kernel_valid`.

---
 rtl/c1weights_loader_if.sv | 38 +++
 rtl/c1weights_loader.sv | 136 +++++++++++++
 tb/tb_c1weights_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1weights_loader_if.sv
// Bus bundle between the conv1 weight loader, the weight ROM and the MAC array.
// CNN_WLOAD_CHECKSUM_EN adds the checksum signal to both modports.
`timescale 1ns/1ps

interface c1weights_loader_if #(
    parameter int PARA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25,
    parameter int ADDR_WIDTH  = 5
);
    logic                              start;
    logic [ADDR_WIDTH-1:0]             rom_raddr;
    logic [PARA_WIDTH-1:0]             rom_dout;
    logic [KERNEL_SIZE*PARA_WIDTH-1:0] kernel_flat;
    logic                              busy;
    logic                              done;
    logic                              kernel_valid;
`ifdef CNN_WLOAD_CHECKSUM_EN
    logic [PARA_WIDTH+ADDR_WIDTH-1:0]  checksum;

    modport master (
        input  start, rom_dout,
        output rom_raddr, kernel_flat, busy, done, kernel_valid, checksum
    );
    modport slave (
        output start, rom_dout,
        input  rom_raddr, kernel_flat, busy, done, kernel_valid, checksum
    );
`else
    modport master (
        input  start, rom_dout,
        output rom_raddr, kernel_flat, busy, done, kernel_valid
    );
    modport slave (
        output start, rom_dout,
        input  rom_raddr, kernel_flat, busy, done, kernel_valid
    );
`endif
endinterface

// File: rtl/c1weights_loader.sv
// Walks the conv1 weight ROM and assembles the weights into a flat kernel bus.
// Optional weight checksum output is enabled by defining CNN_WLOAD_CHECKSUM_EN.
`timescale 1ns/1ps

module c1weights_loader #(
    parameter int PARA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic              clk,
    input  logic              rst,
    c1weights_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_SIZE - 1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next;
    logic                  start_accept;
    logic                  cap_en_reg;
    logic [ADDR_WIDTH-1:0] cap_idx_reg;
    logic                  done_reg;
    logic                  valid_reg;
    logic                  last_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            raddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            raddr_reg <= raddr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        raddr_next   = raddr_reg;
        start_accept = 1'b0;
        case (state_reg)
            IDLE: begin
                raddr_next = '0;
                if (bus.start) begin
                    state_next   = FETCH;
                    start_accept = 1'b1;
                end
            end
            FETCH: begin
                if (raddr_reg == LAST_ADDR) begin
                    state_next = DRAIN;
                    raddr_next = '0;
                end else begin
                    raddr_next = raddr_reg + 1'b1;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                raddr_next = '0;
            end
            default: begin
                state_next = IDLE;
                raddr_next = '0;
            end
        endcase
    end

    // Capture pipeline delays the address by one cycle to line up with the ROM's registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_en_reg  <= 1'b0;
            cap_idx_reg <= '0;
        end else if (start_accept) begin
            cap_en_reg  <= 1'b0;
            cap_idx_reg <= '0;
        end else begin
            cap_en_reg  <= (state_reg == FETCH);
            cap_idx_reg <= raddr_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_slot
            logic [PARA_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (cap_en_reg && (cap_idx_reg == ADDR_WIDTH'(gi))) begin
                    slot_reg <= bus.rom_dout;
                end
            end

            assign bus.kernel_flat[gi*PARA_WIDTH +: PARA_WIDTH] = slot_reg;
        end
    endgenerate

    assign last_cap = cap_en_reg && (cap_idx_reg == LAST_ADDR);

    // kernel_valid can only be set in DRAIN and only cleared in IDLE, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            done_reg <= last_cap;
            if (start_accept) begin
                valid_reg <= 1'b0;
            end else if (last_cap) begin
                valid_reg <= 1'b1;
            end
        end
    end

`ifdef CNN_WLOAD_CHECKSUM_EN
    logic [PARA_WIDTH+ADDR_WIDTH-1:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (start_accept) begin
            sum_reg <= '0;
        end else if (cap_en_reg) begin
            sum_reg <= sum_reg + {{ADDR_WIDTH{1'b0}}, bus.rom_dout};
        end
    end

    assign bus.checksum = sum_reg;
`endif

    assign bus.rom_raddr    = raddr_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.done         = done_reg;
    assign bus.kernel_valid = valid_reg;

endmodule

// File: tb/tb_c1weights_loader.sv
// Self-checking bench for c1weights_loader: timeline reference model, pattern table, corner sequences.
`timescale 1ns/1ps

module tb_c1weights_loader;
    localparam int PW = 8;
    localparam int KS = 25;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    c1weights_loader_if #(.PARA_WIDTH(PW), .KERNEL_SIZE(KS), .ADDR_WIDTH(AW)) bus ();

    c1weights_loader #(.PARA_WIDTH(PW), .KERNEL_SIZE(KS), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Weight ROM with one cycle of registered read latency.
    logic [PW-1:0] rom_mem [32];
    always @(posedge clk) bus.rom_dout <= rom_mem[bus.rom_raddr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges elapsed since the accepted start, -1 when idle.
    int            m_since;
    logic          m_done;
    logic          m_valid;
    logic [PW-1:0] m_slot [KS];
    int            m_sum;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_since = -1;
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_sum   = 0;
        for (int i = 0; i < KS; i++) m_slot[i] = '0;
    endtask

    task automatic model_edge(input logic s);
        m_done = 1'b0;
        if (m_since < 0) begin
            if (s) begin
                m_since = 0;
                m_valid = 1'b0;
                m_sum   = 0;
            end
        end else begin
            m_since++;
            if (m_since >= 2) begin
                m_slot[m_since-2] = rom_mem[m_since-2];
                m_sum += int'(rom_mem[m_since-2]);
            end
            if (m_since == KS + 1) begin
                m_done  = 1'b1;
                m_valid = 1'b1;
                m_since = -1;
            end
        end
    endtask

    task automatic compare_model();
        logic [KS*PW-1:0] exp_flat;
        int exp_addr;
        for (int i = 0; i < KS; i++) exp_flat[i*PW +: PW] = m_slot[i];
        exp_addr = (m_since >= 0 && m_since <= KS - 1) ? m_since : 0;
        chk("rom_raddr", 256'(bus.rom_raddr), 256'(exp_addr));
        chk("busy", 256'(bus.busy), 256'(m_since >= 0));
        chk("done", 256'(bus.done), 256'(m_done));
        chk("kernel_valid", 256'(bus.kernel_valid), 256'(m_valid));
        chk("kernel_flat", 256'(bus.kernel_flat), 256'(exp_flat));
`ifdef CNN_WLOAD_CHECKSUM_EN
        chk("checksum", 256'(bus.checksum), 256'(m_sum));
`endif
    endtask

    // One clock: model follows the posedge, outputs are compared on the negedge.
    task automatic tick();
        logic s;
        s = bus.start;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(s);
        @(negedge clk);
        compare_model();
    endtask

    function automatic logic [PW-1:0] pat_val(input int p, input int i);
        case (p)
            0: return '0;
            1: return 8'hFF;
            2: return PW'(i + 1);
            default: return PW'(i * 10);
        endcase
    endfunction

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < 60);
        if (!bus.done) chk({name, "_timeout"}, 256'(0), 256'(1));
    endtask

    typedef struct {
        int            pattern;
        int            exp_sum;
        logic [PW-1:0] exp_first;
        logic [PW-1:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n;
        int pulses;
        int first_done;
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) rom_mem[i] = '0;
        model_reset();

        vecs[0] = '{pattern: 0, exp_sum: 0,    exp_first: 8'h00, exp_last: 8'h00};
        vecs[1] = '{pattern: 1, exp_sum: 6375, exp_first: 8'hFF, exp_last: 8'hFF};
        vecs[2] = '{pattern: 2, exp_sum: 325,  exp_first: 8'd1,  exp_last: 8'd25};
        vecs[3] = '{pattern: 3, exp_sum: 3000, exp_first: 8'd0,  exp_last: 8'd240};

        // Reset state
        @(negedge clk);
        tick();
        tick();
        chk("reset_raddr", 256'(bus.rom_raddr), 256'(0));
        chk("reset_flat", 256'(bus.kernel_flat), 256'(0));
        chk("reset_valid", 256'(bus.kernel_valid), 256'(0));
        rst = 1'b0;
        tick();

        // Table-driven loads
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < KS; i++) rom_mem[i] = pat_val(vecs[v].pattern, i);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            wait_done("table_done", n);
            chk("table_latency", 256'(n), 256'(KS + 1));
            chk("table_first", 256'(bus.kernel_flat[0 +: PW]), 256'(vecs[v].exp_first));
            chk("table_last", 256'(bus.kernel_flat[(KS-1)*PW +: PW]), 256'(vecs[v].exp_last));
            chk("table_valid", 256'(bus.kernel_valid), 256'(1));
`ifdef CNN_WLOAD_CHECKSUM_EN
            chk("table_checksum", 256'(bus.checksum), 256'(vecs[v].exp_sum));
`endif
            tick();
            chk("table_done_pulse", 256'(bus.done), 256'(0));
            $display("load pattern %0d: latency %0d slot0 %0h slot24 %0h", vecs[v].pattern, n,
                     bus.kernel_flat[0 +: PW], bus.kernel_flat[(KS-1)*PW +: PW]);
        end

        // start re-asserted at E5 and E15 is ignored
        for (int i = 0; i < KS; i++) rom_mem[i] = pat_val(2, i);
        bus.start = 1'b1;
        tick();
        pulses = 0;
        first_done = 0;
        for (int e = 1; e <= 40; e++) begin
            bus.start = (e == 5 || e == 15);
            tick();
            if (bus.done) begin
                pulses++;
                if (first_done == 0) first_done = e;
            end
        end
        bus.start = 1'b0;
        chk("ignored_start_done_edge", 256'(first_done), 256'(KS + 1));
        chk("ignored_start_pulses", 256'(pulses), 256'(1));
        $display("ignored starts: done after E%0d, %0d pulse(s)", first_done, pulses);

        // start held high: kernel_valid low for KS+1 cycles per load
        bus.start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                tick();
                if (!bus.kernel_valid) n++;
            end while (!bus.kernel_valid && n < 60);
            chk("held_valid_low", 256'(n), 256'(KS + 1));
            chk("held_done", 256'(bus.done), 256'(1));
            $display("held start load %0d: kernel_valid low %0d cycles", r, n);
        end
        bus.start = 1'b0;
        repeat (3) tick();

        // start in the cycle done is high
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("sd_first", n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("sd_valid_low", 256'(bus.kernel_valid), 256'(0));
        chk("sd_busy", 256'(bus.busy), 256'(1));
        wait_done("sd_second", n);
        chk("sd_latency", 256'(n), 256'(KS + 1));
        $display("start at done: next done %0d cycles later", n);

        // Asynchronous reset mid-FETCH at rom_raddr=12
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.rom_raddr != 12 && n < 40) begin
            tick();
            n++;
        end
        chk("rst_reach_addr12", 256'(bus.rom_raddr), 256'(12));
        #2 rst = 1'b1;
        #1;
        chk("rst_raddr", 256'(bus.rom_raddr), 256'(0));
        chk("rst_flat", 256'(bus.kernel_flat), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_valid", 256'(bus.kernel_valid), 256'(0));
`ifdef CNN_WLOAD_CHECKSUM_EN
        chk("rst_checksum", 256'(bus.checksum), 256'(0));
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (bus.done) pulses++;
        end
        chk("rst_no_done", 256'(pulses), 256'(0));
        $display("async reset at addr 12: outputs cleared, %0d done pulses after release", pulses);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            if (m_since < 0 && $urandom_range(0, 3) == 0)
                for (int i = 0; i < KS; i++) rom_mem[i] = PW'($urandom);
            bus.start = ($urandom_range(0, 9) == 0);
            tick();
            if (bus.done) $display("random load done at cycle %0d", c);
        end
        bus.start = 1'b0;
        repeat (KS + 3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
